// File: rtl/instr_encoder_loader_if.sv
// ---------------------------------------------------------------------------
// instr_encoder_loader_if
//   Groups the request handshake from the boot/test sequencer and the
//   instruction-memory write port of instr_encoder_loader.
//
//   Request side : in_valid, in_ready, in_op, in_rs, in_rt, in_rd,
//                  in_shamt, in_imm, in_last
//   Memory side  : mem_we, mem_addr, mem_wdata, mem_ack
//
//   modport master : sequencer + memory model (drives requests and mem_ack)
//   modport slave  : the loader (drives in_ready and the write port)
// ---------------------------------------------------------------------------
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [15:0]       in_imm;
  logic              in_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_last,
    output mem_ack,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_last,
    input  mem_ack,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// instr_encoder_loader
//   Turns symbolic instruction requests into 32-bit MIPS machine words and
//   writes them to instruction memory at an auto-incrementing word address.
//   Used to load a program before the core leaves reset.
//
//   Ports
//     clk, rst_n  : clock, asynchronous active-low reset
//     i_start     : pulse; restart at BASE_ADDR, clear count and flags
//     if_bus      : request handshake + memory write port (slave modport)
//     o_done      : load finished (last instruction written or memory full)
//     o_full      : final address written, no space remains
//     o_err       : sticky, an illegal op (15) was received
//     o_count     : words written since reset/start
//
//   Optional build macro ILLEGAL_AS_NOP_EN:
//     defined   - an illegal op is written as 0x00000000 (sll $0,$0,0)
//     undefined - an illegal op is dropped without a write
//   err is set in both builds.
// ---------------------------------------------------------------------------
module instr_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  instr_encoder_loader_if.slave if_bus,
  output logic                  o_done,
  output logic                  o_full,
  output logic                  o_err,
  output logic [ADDR_W:0]       o_count
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  // Major opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_SPEC2 = 6'b011100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  // Function codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_CLO = 6'b100001;
  localparam logic [5:0] FN_CLZ = 6'b100000;
  localparam logic [5:0] FN_MUL = 6'b000010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Returns {legal, word}. Unused fields are zero; shift ops force rs=0,
  // clo/clz place rd in the rt field as the controller expects.
  function automatic logic [32:0] encode_instr(
    input logic [3:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [15:0] imm
  );
    logic [32:0] res;
    case (op)
      4'd0:    res = {1'b1, OP_RTYPE, rs, rt, rd, 5'd0, FN_ADD};
      4'd1:    res = {1'b1, OP_RTYPE, rs, rt, rd, 5'd0, FN_SUB};
      4'd2:    res = {1'b1, OP_RTYPE, rs, rt, rd, 5'd0, FN_AND};
      4'd3:    res = {1'b1, OP_RTYPE, rs, rt, rd, 5'd0, FN_OR};
      4'd4:    res = {1'b1, OP_RTYPE, rs, rt, rd, 5'd0, FN_SLT};
      4'd5:    res = {1'b1, OP_RTYPE, 5'd0, rt, rd, shamt, FN_SLL};
      4'd6:    res = {1'b1, OP_RTYPE, 5'd0, rt, rd, shamt, FN_SRL};
      4'd7:    res = {1'b1, OP_SPEC2, rs, rd, rd, 5'd0, FN_CLO};
      4'd8:    res = {1'b1, OP_SPEC2, rs, rd, rd, 5'd0, FN_CLZ};
      4'd9:    res = {1'b1, OP_SPEC2, rs, rt, rd, 5'd0, FN_MUL};
      4'd10:   res = {1'b1, OP_ADDI, rs, rt, imm};
      4'd11:   res = {1'b1, OP_ORI,  rs, rt, imm};
      4'd12:   res = {1'b1, OP_LW,   rs, rt, imm};
      4'd13:   res = {1'b1, OP_SW,   rs, rt, imm};
      4'd14:   res = {1'b1, OP_BNE,  rs, rt, imm};
      default: res = {1'b0, 32'h0000_0000};
    endcase
    return res;
  endfunction

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [31:0]       r_wdata, w_wdata_nxt;
  logic              r_we, w_we_nxt;
  logic              r_full, w_full_nxt;
  logic              r_err, w_err_nxt;
  logic              r_last, w_last_nxt;
  logic [ADDR_W:0]   r_count, w_count_nxt;
  logic [32:0]       w_enc;

  assign w_enc = encode_instr(if_bus.in_op, if_bus.in_rs, if_bus.in_rt,
                              if_bus.in_rd, if_bus.in_shamt, if_bus.in_imm);

  // Outputs are straight register or state decodes, no input-to-output paths.
  assign if_bus.in_ready  = (r_state == ST_IDLE);
  assign if_bus.mem_we    = r_we;
  assign if_bus.mem_addr  = r_addr;
  assign if_bus.mem_wdata = r_wdata;
  assign o_done           = (r_state == ST_DONE);
  assign o_full           = r_full;
  assign o_err            = r_err;
  assign o_count          = r_count;

  // Next-state and next-register values; start overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_we_nxt    = r_we;
    w_full_nxt  = r_full;
    w_err_nxt   = r_err;
    w_last_nxt  = r_last;
    w_count_nxt = r_count;
    if (i_start) begin
      w_state_nxt = ST_IDLE;
      w_addr_nxt  = BASE;
      w_we_nxt    = 1'b0;
      w_full_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      w_last_nxt  = 1'b0;
      w_count_nxt = {(ADDR_W+1){1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (if_bus.in_valid) begin
            if (w_enc[32]) begin
              w_wdata_nxt = w_enc[31:0];
              w_last_nxt  = if_bus.in_last;
              w_we_nxt    = 1'b1;
              w_state_nxt = ST_WRITE;
            end else begin
              w_err_nxt = 1'b1;
`ifdef ILLEGAL_AS_NOP_EN
              w_wdata_nxt = 32'h0000_0000;
              w_last_nxt  = if_bus.in_last;
              w_we_nxt    = 1'b1;
              w_state_nxt = ST_WRITE;
`else
              w_state_nxt = ST_IDLE;
`endif
            end
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_WRITE: begin
          // Address and data hold until the memory acknowledges.
          if (if_bus.mem_ack) begin
            w_we_nxt    = 1'b0;
            w_count_nxt = r_count + (ADDR_W+1)'(1'b1);
            if (r_last) begin
              w_state_nxt = ST_DONE;
            end else if (&r_addr) begin
              w_full_nxt  = 1'b1;
              w_state_nxt = ST_DONE;
            end else begin
              w_addr_nxt  = r_addr + ADDR_W'(1'b1);
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_state_nxt = ST_WRITE;
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_DONE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_we_nxt    = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers; reset drops any in-flight write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_addr  <= BASE;
      r_wdata <= 32'h0000_0000;
      r_we    <= 1'b0;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
      r_last  <= 1'b0;
      r_count <= {(ADDR_W+1){1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_we    <= w_we_nxt;
      r_full  <= w_full_nxt;
      r_err   <= w_err_nxt;
      r_last  <= w_last_nxt;
      r_count <= w_count_nxt;
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench: expected {addr,data} pushed when a request is driven,
// popped and compared when the memory accepts a write.
module tb_instr_encoder_loader;

  logic clk = 1'b0;
  logic rst_n;
  logic r_start_a, r_start_b;
  logic ack_en_a, ack_en_b;
  logic o_done_a, o_full_a, o_err_a;
  logic o_done_b, o_full_b, o_err_b;
  logic [8:0] o_count_a;
  logic [2:0] o_count_b;

  int n_checks = 0;
  int n_pass   = 0;

  logic [39:0] qa[$];
  logic [39:0] qb[$];
  logic [39:0] e_a, e_b;
  logic [7:0]  exp_addr_a;
  logic [1:0]  exp_addr_b;

  instr_encoder_loader_if #(.ADDR_W(8)) ifa ();
  instr_encoder_loader_if #(.ADDR_W(2)) ifb ();

  assign ifa.mem_ack = ifa.mem_we & ack_en_a;
  assign ifb.mem_ack = ifb.mem_we & ack_en_b;

  instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .i_start(r_start_a), .if_bus(ifa.slave),
    .o_done(o_done_a), .o_full(o_full_a), .o_err(o_err_a), .o_count(o_count_a)
  );

  instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .i_start(r_start_b), .if_bus(ifb.slave),
    .o_done(o_done_b), .o_full(o_full_b), .o_err(o_err_b), .o_count(o_count_b)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Write monitor for DUT A
  always @(negedge clk) begin
    if (rst_n && ifa.mem_we && ifa.mem_ack && !r_start_a) begin
      check_eq("a_sb_nonempty", 32'(qa.size() != 0), 32'd1);
      if (qa.size() != 0) begin
        e_a = qa.pop_front();
        check_eq("a_addr", 32'(ifa.mem_addr), 32'(e_a[39:32]));
        check_eq("a_data", ifa.mem_wdata, e_a[31:0]);
      end
    end
  end

  // Write monitor for DUT B
  always @(negedge clk) begin
    if (rst_n && ifb.mem_we && ifb.mem_ack && !r_start_b) begin
      check_eq("b_sb_nonempty", 32'(qb.size() != 0), 32'd1);
      if (qb.size() != 0) begin
        e_b = qb.pop_front();
        check_eq("b_addr", 32'(ifb.mem_addr), 32'(e_b[39:32]));
        check_eq("b_data", ifb.mem_wdata, e_b[31:0]);
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge after the request was presented.
  task automatic send_a(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                        input logic last, input logic [31:0] exp_word, input bit exp_write);
    for (int k = 0; k < 20 && !ifa.in_ready; k++) @(negedge clk);
    check_eq("a_ready_wait", 32'(ifa.in_ready), 32'd1);
    ifa.in_valid = 1'b1; ifa.in_op = op; ifa.in_rs = rs; ifa.in_rt = rt;
    ifa.in_rd = rd; ifa.in_shamt = sh; ifa.in_imm = imm; ifa.in_last = last;
    if (exp_write) begin
      qa.push_back({exp_addr_a, exp_word});
      exp_addr_a = exp_addr_a + 8'd1;
    end
    @(negedge clk);
    ifa.in_valid = 1'b0;
    ifa.in_last  = 1'b0;
  endtask

  task automatic wait_ready_a();
    for (int k = 0; k < 20 && !ifa.in_ready; k++) @(negedge clk);
  endtask

  task automatic pulse_start_a();
    r_start_a = 1'b1;
    @(negedge clk);
    r_start_a  = 1'b0;
    exp_addr_a = 8'd0;
  endtask

  initial begin
    rst_n = 1'b0; r_start_a = 1'b0; r_start_b = 1'b0;
    ack_en_a = 1'b1; ack_en_b = 1'b1;
    exp_addr_a = 8'd0; exp_addr_b = 2'd0;
    ifa.in_valid = 1'b0; ifa.in_op = 4'd0; ifa.in_rs = 5'd0; ifa.in_rt = 5'd0;
    ifa.in_rd = 5'd0; ifa.in_shamt = 5'd0; ifa.in_imm = 16'h0; ifa.in_last = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_op = 4'd0; ifb.in_rs = 5'd0; ifb.in_rt = 5'd0;
    ifb.in_rd = 5'd0; ifb.in_shamt = 5'd0; ifb.in_imm = 16'h0; ifb.in_last = 1'b0;
    repeat (2) @(negedge clk);
    // Reset state
    check_eq("rst_we",    32'(ifa.mem_we), 32'd0);
    check_eq("rst_addr",  32'(ifa.mem_addr), 32'd0);
    check_eq("rst_wdata", ifa.mem_wdata, 32'd0);
    check_eq("rst_done",  32'(o_done_a), 32'd0);
    check_eq("rst_full",  32'(o_full_a), 32'd0);
    check_eq("rst_err",   32'(o_err_a), 32'd0);
    check_eq("rst_count", 32'(o_count_a), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // add rd=3, rs=1, rt=2 with immediate ack
    send_a(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 1'b0, 32'h0022_1820, 1'b1);
    check_eq("t1_rdy_busy", 32'(ifa.in_ready), 32'd0);
    check_eq("t1_we_high",  32'(ifa.mem_we), 32'd1);
    @(negedge clk);
    check_eq("t1_rdy_back", 32'(ifa.in_ready), 32'd1);
    check_eq("t1_count",    32'(o_count_a), 32'd1);

    // addi then sll with in_last
    pulse_start_a();
    check_eq("t2_start_addr",  32'(ifa.mem_addr), 32'd0);
    check_eq("t2_start_count", 32'(o_count_a), 32'd0);
    send_a(4'd10, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005, 1'b0, 32'h2008_0005, 1'b1);
    send_a(4'd5,  5'd0, 5'd1, 5'd2, 5'd4, 16'h0000, 1'b1, 32'h0001_1100, 1'b1);
    for (int k = 0; k < 20 && !o_done_a; k++) @(negedge clk);
    check_eq("t2_done",  32'(o_done_a), 32'd1);
    check_eq("t2_count", 32'(o_count_a), 32'd2);
    check_eq("t2_rdy",   32'(ifa.in_ready), 32'd0);
    // Requests in DONE are ignored
    ifa.in_valid = 1'b1; ifa.in_op = 4'd1;
    repeat (3) @(negedge clk);
    ifa.in_valid = 1'b0;
    check_eq("t2_ign_count", 32'(o_count_a), 32'd2);
    check_eq("t2_ign_done",  32'(o_done_a), 32'd1);
    pulse_start_a();
    check_eq("t2_restart_done", 32'(o_done_a), 32'd0);

    // clz rd=5, rs=4 with ack held off for three cycles
    ack_en_a = 1'b0;
    send_a(4'd8, 5'd4, 5'd0, 5'd5, 5'd0, 16'h0, 1'b0, 32'h7085_2820, 1'b1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      check_eq("t3_we",   32'(ifa.mem_we), 32'd1);
      check_eq("t3_addr", 32'(ifa.mem_addr), 32'd0);
      check_eq("t3_data", ifa.mem_wdata, 32'h7085_2820);
      check_eq("t3_rdy",  32'(ifa.in_ready), 32'd0);
    end
    @(posedge clk); #1 ack_en_a = 1'b1;
    @(negedge clk);
    check_eq("t3_we4",   32'(ifa.mem_we), 32'd1);
    check_eq("t3_data4", ifa.mem_wdata, 32'h7085_2820);
    check_eq("t3_rdy4",  32'(ifa.in_ready), 32'd0);
    @(negedge clk);
    check_eq("t3_we_off", 32'(ifa.mem_we), 32'd0);
    check_eq("t3_count",  32'(o_count_a), 32'd1);

    // bne then illegal op
    send_a(4'd14, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFE, 1'b0, 32'h1422_FFFE, 1'b1);
`ifdef ILLEGAL_AS_NOP_EN
    send_a(4'd15, 5'd3, 5'd3, 5'd3, 5'd3, 16'h1234, 1'b0, 32'h0000_0000, 1'b1);
`else
    send_a(4'd15, 5'd3, 5'd3, 5'd3, 5'd3, 16'h1234, 1'b0, 32'h0000_0000, 1'b0);
`endif
    check_eq("t4_err", 32'(o_err_a), 32'd1);
    wait_ready_a();
`ifdef ILLEGAL_AS_NOP_EN
    check_eq("t4_count", 32'(o_count_a), 32'd3);
`else
    check_eq("t4_count", 32'(o_count_a), 32'd2);
`endif
    send_a(4'd0, 5'd0, 5'd0, 5'd7, 5'd0, 16'h0, 1'b0, 32'h0000_3820, 1'b1);
    wait_ready_a();
    check_eq("t4_err_sticky", 32'(o_err_a), 32'd1);

    // start beats a simultaneous accept
    ifa.in_valid = 1'b1; ifa.in_op = 4'd0; r_start_a = 1'b1;
    @(negedge clk);
    ifa.in_valid = 1'b0; r_start_a = 1'b0; exp_addr_a = 8'd0;
    check_eq("t5_we",    32'(ifa.mem_we), 32'd0);
    check_eq("t5_count", 32'(o_count_a), 32'd0);
    check_eq("t5_err",   32'(o_err_a), 32'd0);
    check_eq("t5_rdy",   32'(ifa.in_ready), 32'd1);

    // start beats a simultaneous mem_ack
    ack_en_a = 1'b0;
    send_a(4'd1, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1 ack_en_a = 1'b1; r_start_a = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 r_start_a = 1'b0;
    @(negedge clk);
    check_eq("t5_ack_we",    32'(ifa.mem_we), 32'd0);
    check_eq("t5_ack_count", 32'(o_count_a), 32'd0);
    check_eq("t5_ack_addr",  32'(ifa.mem_addr), 32'd0);

    // reset during a pending write
    ack_en_a = 1'b0;
    send_a(4'd2, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 1'b0, 32'h0, 1'b0);
    check_eq("t6_we_pre", 32'(ifa.mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_we_drop", 32'(ifa.mem_we), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; ack_en_a = 1'b1;
    @(negedge clk);
    check_eq("t6_we",    32'(ifa.mem_we), 32'd0);
    check_eq("t6_addr",  32'(ifa.mem_addr), 32'd0);
    check_eq("t6_count", 32'(o_count_a), 32'd0);
    check_eq("t6_rdy",   32'(ifa.in_ready), 32'd1);

    // ADDR_W=2 instance: fill all four words without in_last
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 20 && !ifb.in_ready; k++) @(negedge clk);
      check_eq("b_ready_wait", 32'(ifb.in_ready), 32'd1);
      if (i == 3) check_eq("b_not_full_yet", 32'(o_full_b), 32'd0);
      ifb.in_valid = 1'b1; ifb.in_op = 4'd11; ifb.in_rs = 5'd0;
      ifb.in_rt = 5'(i); ifb.in_imm = 16'(i);
      qb.push_back({6'd0, exp_addr_b, 6'b001101, 5'd0, 5'(i), 16'(i)});
      exp_addr_b = exp_addr_b + 2'd1;
      @(negedge clk);
      ifb.in_valid = 1'b0;
    end
    for (int k = 0; k < 20 && !o_done_b; k++) @(negedge clk);
    check_eq("b_full",  32'(o_full_b), 32'd1);
    check_eq("b_done",  32'(o_done_b), 32'd1);
    check_eq("b_count", 32'(o_count_b), 32'd4);
    check_eq("b_addr3", 32'(ifb.mem_addr), 32'd3);
    ifb.in_valid = 1'b1; ifb.in_op = 4'd0;
    repeat (3) @(negedge clk);
    check_eq("b_rdy_full", 32'(ifb.in_ready), 32'd0);
    check_eq("b_count_held", 32'(o_count_b), 32'd4);
    ifb.in_valid = 1'b0;
    r_start_b = 1'b1;
    @(negedge clk);
    r_start_b = 1'b0;
    check_eq("b_st_addr",  32'(ifb.mem_addr), 32'd0);
    check_eq("b_st_full",  32'(o_full_b), 32'd0);
    check_eq("b_st_done",  32'(o_done_b), 32'd0);
    check_eq("b_st_count", 32'(o_count_b), 32'd0);
    check_eq("b_st_rdy",   32'(ifb.in_ready), 32'd1);

    check_eq("a_sb_drained", 32'(qa.size()), 32'd0);
    check_eq("b_sb_drained", 32'(qb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the control decoder: accepts symbolic instruction requests and emits 32-bit MIPS machine words using the same opcode/funct encodings the controller decodes.
- Writes each encoded word into instruction memory at an auto-incrementing word address.
- Sits between the test/boot sequencer and the instruction-memory write port; used to load programs before the core leaves reset.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- BASE_ADDR, 0, first word address after reset or `start`.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse: restart load at BASE_ADDR, clear count/flags.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid&in_ready.
- in_op  in  4  mnemonic: 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 sll, 6 srl, 7 clo, 8 clz, 9 mul, 10 addi, 11 ori, 12 lw, 13 sw, 14 bne, 15 illegal.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields.
- in_imm  in  16  immediate or branch offset.
- in_last  in  1  final instruction of the program.
- mem_we  out  1  write strobe; held until mem_ack.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  encoded word.
- mem_ack  in  1  memory accepted write.
- done  out  1  load finished.
- full  out  1  last address written; no space remains.
- err  out  1  sticky; an illegal op was received.
- count  out  ADDR_W+1  words written since start/reset.

Behaviour:
- Reset (async, rst_n=0): state IDLE, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, done=0, full=0, err=0, count=0. Reset mid-write drops mem_we immediately and does not retry the write.
- Field layout: [31:26] op, [25:21] rs, [20:16] rt, [15:11] rd, [10:6] shamt, [5:0] funct. Unused fields are 0.
- R-type ops use op 000000. Funct codes: add 100000, sub 100010, and 100100, or 100101, slt 101010, sll 000000, srl 000010.
- sll/srl: rs field = 0, shamt = in_shamt. All other R-type ops: shamt = 0.
- SPECIAL2 ops use op 011100. Funct codes: clo 100001, clz 100000, mul 000010. For clo/clz, the rt field = in_rd.
- I-type ops: addi 001000, ori 001101, lw 100011, sw 101011, bne 000101. Fields are rs, rt, imm[15:0], passed through unchanged.
- FSM states: IDLE, WRITE, DONE.
  - IDLE: in_ready=1. On accept of a legal op, register the encoded word and go to WRITE. mem_we rises the cycle after accept (1-cycle latency).
  - WRITE: in_ready=0; mem_we=1; mem_addr and mem_wdata stable until the cycle mem_ack=1. On ack: count++.
    - If the latched in_last=1: go to DONE.
    - Else if mem_addr is all-ones: set full=1 and go to DONE.
    - Else: mem_addr++ and return to IDLE.
  - DONE: done=1, in_ready=0; in_valid is ignored.
- Illegal op (15): err set (sticky) and no write. The FSM stays in IDLE, unless ILLEGAL_AS_NOP_EN is defined.
- start: in any state, returns to IDLE next cycle with mem_addr=BASE_ADDR, count=0, done=full=err=0, mem_we=0.
- start has priority over accept and over mem_ack in the same cycle.
- mem_ack while mem_we=0 is ignored.

Optional Feature:
- Macro: ILLEGAL_AS_NOP_EN.
- Defined: an illegal op is encoded as 0x00000000 (sll $0,$0,0) and written like a normal request, advancing address and count; err is still set.
- Undefined: an illegal op is dropped without a write, as described in Behaviour.

Test Plan:
- add rd=3,rs=1,rt=2 at BASE_ADDR=0, mem_ack same cycle as mem_we -> mem_wdata=0x00221820 at addr 0; count=1; in_ready high again two cycles after accept.
- addi rt=8,rs=0,imm=0x0005, then sll rd=2,rt=1,shamt=4 with in_last on the sll -> 0x20080005 at addr 0, 0x00011100 at addr 1; done=1; count=2.
- clz rd=5,rs=4, with mem_ack held low 3 cycles -> mem_we, addr, and data (0x70852820) stable for 4 cycles; in_ready=0 throughout.
- bne rs=1,rt=2,imm=0xFFFE -> 0x1422FFFE. Then in_op=15 -> err=1, with no write (macro undefined) or a 0x00000000 write at the next address (macro defined).
- ADDR_W=2: four writes without in_last -> full=1 and done=1 after the write to addr 3; a following in_valid is not accepted. start -> addr 0, flags cleared.
- rst_n low while mem_we=1 -> mem_we=0 immediately; after release: addr=BASE_ADDR, count=0, in_ready=1.
